// File: rtl/vpu_pkg.sv
// -----------------------------------------------------------------------------
// vpu_pkg
// Shared definitions for the VPU command sequencer:
//   state_t    - sequencer FSM states
//   cmd_op_t   - command operation codes
//   PATH_*     - vpu_data_pathway encodings
//   op_to_path - maps a command operation onto its pathway encoding
// -----------------------------------------------------------------------------
package vpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONFIG = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_PASS  = 2'b00,
        OP_FWD   = 2'b01,
        OP_TRANS = 2'b10,
        OP_BWD   = 2'b11
    } cmd_op_t;

    localparam logic [3:0] PATH_NONE  = 4'b0000;
    localparam logic [3:0] PATH_FWD   = 4'b1100;
    localparam logic [3:0] PATH_TRANS = 4'b1111;
    localparam logic [3:0] PATH_BWD   = 4'b0001;

    function automatic logic [3:0] op_to_path(input cmd_op_t op);
        case (op)
            OP_FWD:   return PATH_FWD;
            OP_TRANS: return PATH_TRANS;
            OP_BWD:   return PATH_BWD;
            default:  return PATH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vpu_lane_counter.sv
// -----------------------------------------------------------------------------
// vpu_lane_counter
// Counts output valids of one VPU lane, saturating at the command row count.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clear        - synchronous clear (new command or abort)
//   enable       - counting window is open (RUN or DRAIN)
//   valid        - lane output valid
//   limit        - row count of the current command
//   full_next    - lane is full, or becomes full with this cycle's valid
//   overflow     - a valid arrived while the lane was already full
// -----------------------------------------------------------------------------
module vpu_lane_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        valid,
    input  logic [15:0] limit,
    output logic        full_next,
    output logic        overflow
);

    logic [15:0] count;
    logic        hit;
    logic        at_limit;

    assign hit      = enable && valid;
    assign at_limit = (count == limit);
    assign overflow = hit && at_limit;
    // Look-ahead so the sequencer can leave DRAIN on the same edge that
    // records the final valid of the slowest lane.
    assign full_next = at_limit || (hit && ((count + 16'd1) == limit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (hit && !at_limit) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/vpu_sequencer.sv
// -----------------------------------------------------------------------------
// vpu_sequencer
// Accepts one command at a time, registers the VPU configuration for it,
// issues cmd_rows rows, then waits for every VPU lane to produce cmd_rows
// outputs (or for the drain idle timeout) before pulsing done.
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             - command handshake (ready only in IDLE)
//   cmd_op, cmd_rows                - operation and number of rows
//   cmd_sys_mode, cmd_leak_factor   - configuration captured at accept
//   abort                           - cancels the current command
//   row_valid/row_ready             - row issue handshake
//   vpu_valid_out[N]                - per-lane output valids from the vpu
//   vpu_data_pathway, sys_mode,
//   lr_leak_factor                  - registered vpu configuration
//   busy, done                      - status (done is a 1-cycle pulse)
//   err_timeout, err_overflow       - sticky errors, cleared at next accept
// -----------------------------------------------------------------------------
module vpu_sequencer
    import vpu_pkg::*;
#(
    parameter int N             = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [15:0]  cmd_rows,
    input  logic [1:0]   cmd_sys_mode,
    input  logic [15:0]  cmd_leak_factor,
    input  logic         abort,
    output logic         row_valid,
    input  logic         row_ready,
    input  logic [N-1:0] vpu_valid_out,
    output logic [3:0]   vpu_data_pathway,
    output logic [1:0]   sys_mode,
    output logic [15:0]  lr_leak_factor,
    output logic         busy,
    output logic         done,
    output logic         err_timeout,
    output logic         err_overflow
);

    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   rows_q;
    logic [15:0]   issue_cnt;
    logic [TW-1:0] idle_cnt;
    logic [N-1:0]  lane_full;
    logic [N-1:0]  lane_ovf;

    logic accept;
    logic do_abort;
    logic counting;
    logic lane_clear;
    logic issue;
    logic last_issue;
    logic all_full;
    logic idle_now;
    logic timeout_hit;

    // Ready is held low for as long as reset is asserted.
    assign cmd_ready  = (state == ST_IDLE) && rst_n;
    assign row_valid  = (state == ST_RUN);
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    assign accept     = cmd_valid && cmd_ready;
    assign do_abort   = abort && (state != ST_IDLE);
    assign counting   = (state == ST_RUN) || (state == ST_DRAIN);
    assign lane_clear = accept || do_abort;
    assign issue      = row_valid && row_ready;
    assign last_issue = issue && ((issue_cnt + 16'd1) == rows_q);
    assign all_full   = &lane_full;
    assign idle_now   = ~|vpu_valid_out;
    // Fires on the DRAIN_TIMEOUT-th consecutive idle DRAIN cycle; completion
    // on the same cycle wins over the error.
    assign timeout_hit = (state == ST_DRAIN) && idle_now && !all_full && !do_abort &&
                         (idle_cnt == TW'(DRAIN_TIMEOUT - 1));

    for (genvar i = 0; i < N; i++) begin : g_lane
        vpu_lane_counter u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (lane_clear),
            .enable    (counting),
            .valid     (vpu_valid_out[i]),
            .limit     (rows_q),
            .full_next (lane_full[i]),
            .overflow  (lane_ovf[i])
        );
    end

    always_comb begin
        state_nxt = state;
        if (do_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state_nxt = ST_CONFIG;
                ST_CONFIG: state_nxt = (rows_q == 16'd0) ? ST_DONE : ST_RUN;
                ST_RUN:    if (last_issue) state_nxt = ST_DRAIN;
                ST_DRAIN:  if (all_full || timeout_hit) state_nxt = ST_DONE;
                ST_DONE:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            vpu_data_pathway <= PATH_NONE;
            sys_mode         <= '0;
            lr_leak_factor   <= '0;
            issue_cnt        <= '0;
            idle_cnt         <= '0;
            err_timeout      <= 1'b0;
            err_overflow     <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                vpu_data_pathway <= op_to_path(cmd_op_t'(cmd_op));
                sys_mode         <= cmd_sys_mode;
                lr_leak_factor   <= cmd_leak_factor;
                err_timeout      <= 1'b0;
                err_overflow     <= 1'b0;
            end else begin
                if (state_nxt == ST_IDLE) begin
                    vpu_data_pathway <= PATH_NONE;
                    sys_mode         <= '0;
                    lr_leak_factor   <= '0;
                end
                if (timeout_hit) err_timeout  <= 1'b1;
                if (|lane_ovf)   err_overflow <= 1'b1;
            end

            if (lane_clear) begin
                issue_cnt <= '0;
            end else if (issue) begin
                issue_cnt <= issue_cnt + 16'd1;
            end

            if ((state == ST_DRAIN) && idle_now) begin
                idle_cnt <= idle_cnt + TW'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    // Row limit is pure data: only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) rows_q <= cmd_rows;
    end

endmodule

// File: tb/tb_vpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vpu_sequencer
// Directed bench for vpu_sequencer with a per-cycle reference model.
// -----------------------------------------------------------------------------
module tb_vpu_sequencer;

    localparam int N  = 2;
    localparam int DT = 64;

    localparam int P_IDLE  = 0;
    localparam int P_CFG   = 1;
    localparam int P_RUN   = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic         clk             = 1'b0;
    logic         rst_n           = 1'b0;
    logic         cmd_valid       = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op          = 2'b00;
    logic [15:0]  cmd_rows        = 16'd0;
    logic [1:0]   cmd_sys_mode    = 2'b00;
    logic [15:0]  cmd_leak_factor = 16'd0;
    logic         abort           = 1'b0;
    logic         row_valid;
    logic         row_ready       = 1'b1;
    logic [N-1:0] vpu_valid_out   = '0;
    logic [3:0]   vpu_data_pathway;
    logic [1:0]   sys_mode;
    logic [15:0]  lr_leak_factor;
    logic         busy;
    logic         done;
    logic         err_timeout;
    logic         err_overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vpu_sequencer #(.N(N), .DRAIN_TIMEOUT(DT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_rows         (cmd_rows),
        .cmd_sys_mode     (cmd_sys_mode),
        .cmd_leak_factor  (cmd_leak_factor),
        .abort            (abort),
        .row_valid        (row_valid),
        .row_ready        (row_ready),
        .vpu_valid_out    (vpu_valid_out),
        .vpu_data_pathway (vpu_data_pathway),
        .sys_mode         (sys_mode),
        .lr_leak_factor   (lr_leak_factor),
        .busy             (busy),
        .done             (done),
        .err_timeout      (err_timeout),
        .err_overflow     (err_overflow)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] path_tab [4] = '{4'b0000, 4'b1100, 4'b1111, 4'b0001};

    int          m_ph    = P_IDLE;
    int          m_rows  = 0;
    int          m_issued = 0;
    int          m_idle  = 0;
    int          m_lane [N];
    logic [3:0]  m_path  = 4'b0000;
    logic [1:0]  m_mode  = 2'b00;
    logic [15:0] m_leak  = 16'd0;
    logic        m_etime = 1'b0;
    logic        m_eovf  = 1'b0;
    logic        m_all;

    task automatic m_clear_cfg();
        m_path = 4'b0000;
        m_mode = 2'b00;
        m_leak = 16'd0;
    endtask

    task automatic m_clear_counts();
        m_issued = 0;
        m_idle   = 0;
        for (int i = 0; i < N; i++) m_lane[i] = 0;
    endtask

    initial m_clear_counts();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph    = P_IDLE;
            m_etime = 1'b0;
            m_eovf  = 1'b0;
            m_clear_cfg();
            m_clear_counts();
        end else begin
            if (m_ph == P_RUN || m_ph == P_DRAIN) begin
                for (int i = 0; i < N; i++) begin
                    if (vpu_valid_out[i]) begin
                        if (m_lane[i] == m_rows) m_eovf = 1'b1;
                        else m_lane[i]++;
                    end
                end
            end
            m_all = 1'b1;
            for (int i = 0; i < N; i++) if (m_lane[i] != m_rows) m_all = 1'b0;

            if (abort && m_ph != P_IDLE) begin
                m_ph = P_IDLE;
                m_clear_cfg();
                m_clear_counts();
            end else begin
                case (m_ph)
                    P_IDLE: if (cmd_valid) begin
                        m_ph    = P_CFG;
                        m_path  = path_tab[cmd_op];
                        m_mode  = cmd_sys_mode;
                        m_leak  = cmd_leak_factor;
                        m_rows  = int'(cmd_rows);
                        m_etime = 1'b0;
                        m_eovf  = 1'b0;
                        m_clear_counts();
                    end
                    P_CFG: m_ph = (m_rows == 0) ? P_DONE : P_RUN;
                    P_RUN: if (row_ready) begin
                        m_issued++;
                        if (m_issued == m_rows) begin
                            m_ph   = P_DRAIN;
                            m_idle = 0;
                        end
                    end
                    P_DRAIN: begin
                        if (m_all) begin
                            m_ph = P_DONE;
                        end else begin
                            m_idle = (vpu_valid_out != '0) ? 0 : m_idle + 1;
                            if (m_idle == DT) begin
                                m_etime = 1'b1;
                                m_ph    = P_DONE;
                            end
                        end
                    end
                    default: begin
                        m_ph = P_IDLE;
                        m_clear_cfg();
                    end
                endcase
            end
        end
    end

    // ---------------- per-cycle compare + monitors ----------------
    int   done_seen = 0;
    logic rv_seen   = 1'b0;
    int   hs        = 0;

    always @(posedge clk) begin
        #1;
        check("cmd_ready",    cmd_ready,        (m_ph == P_IDLE) && rst_n);
        check("row_valid",    row_valid,        m_ph == P_RUN);
        check("busy",         busy,             m_ph != P_IDLE);
        check("done",         done,             m_ph == P_DONE);
        check("pathway",      vpu_data_pathway, m_path);
        check("sys_mode",     sys_mode,         m_mode);
        check("leak",         lr_leak_factor,   m_leak);
        check("err_timeout",  err_timeout,      m_etime);
        check("err_overflow", err_overflow,     m_eovf);
        if (done) done_seen++;
        if (row_valid) rv_seen = 1'b1;
    end

    always @(posedge clk) begin
        if (rst_n && row_valid && row_ready) hs++;
    end

    // ---------------- directed stimulus ----------------
    logic [N-1:0] vpat [16];
    logic         rpat [16];

    task automatic clr_pat();
        for (int i = 0; i < 16; i++) begin
            vpat[i] = '0;
            rpat[i] = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send(input logic [1:0] op, input logic [15:0] rows,
                        input logic [1:0] mode, input logic [15:0] leak);
        cmd_valid       = 1'b1;
        cmd_op          = op;
        cmd_rows        = rows;
        cmd_sys_mode    = mode;
        cmd_leak_factor = leak;
        hs        = 0;
        done_seen = 0;
        rv_seen   = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Returns the negedge index (accept edge = 0) at which done is seen, or -1.
    task automatic run_cmd(input int max_cyc, output int at);
        at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                at = i + 2;
                break;
            end
            if (i < 16) begin
                vpu_valid_out = vpat[i];
                row_ready     = rpat[i];
            end else begin
                vpu_valid_out = '0;
                row_ready     = 1'b1;
            end
        end
        vpu_valid_out = '0;
        row_ready     = 1'b1;
    endtask

    int   at;
    logic path_ok;

    initial begin
        clr_pat();
        repeat (3) @(negedge clk);
        check("rst cmd_ready", cmd_ready, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst pathway", vpu_data_pathway, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("release cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // Forward, rows=3, lane 1 skewed by one cycle
        clr_pat();
        vpat[0] = 2'b01; vpat[1] = 2'b11; vpat[2] = 2'b11; vpat[3] = 2'b10;
        send(2'b01, 16'd3, 2'b10, 16'h1234);
        check("fwd pathway@config", vpu_data_pathway, 4'b1100);
        check("fwd leak@config", lr_leak_factor, 16'h1234);
        check("fwd ready@config", cmd_ready, 1'b0);
        run_cmd(20, at);
        check("fwd done_at", at, 6);
        check("fwd pathway@done", vpu_data_pathway, 4'b1100);
        check("fwd issues", hs, 3);
        @(negedge clk);
        check("fwd pathway@idle", vpu_data_pathway, 4'b0000);
        check("fwd done pulse", done, 1'b0);
        check("fwd done count", done_seen, 1);

        // Transition, rows=4, row_ready toggling 1010
        clr_pat();
        for (int i = 0; i < 8; i++) rpat[i] = (i % 2 == 0);
        for (int i = 0; i < 4; i++) vpat[i] = 2'b11;
        send(2'b10, 16'd4, 2'b01, 16'h00ff);
        path_ok = (vpu_data_pathway == 4'b1111);
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (vpu_data_pathway != 4'b1111) path_ok = 1'b0;
            if (i < 16) begin
                vpu_valid_out = vpat[i];
                row_ready     = rpat[i];
            end
        end
        vpu_valid_out = '0;
        row_ready     = 1'b1;
        check("trans pathway steady", path_ok, 1'b1);
        check("trans done", done, 1'b1);
        check("trans handshakes", hs, 4);
        check("trans err_timeout", err_timeout, 1'b0);
        check("trans err_overflow", err_overflow, 1'b0);
        @(negedge clk);

        // Backward, rows=0: CONFIG then DONE
        clr_pat();
        send(2'b11, 16'd0, 2'b11, 16'hbeef);
        check("bwd pathway@config", vpu_data_pathway, 4'b0001);
        run_cmd(10, at);
        check("bwd done_at", at, 2);
        check("bwd row_valid never", rv_seen, 1'b0);
        @(negedge clk);

        // Drain timeout: lane 1 never reports
        clr_pat();
        vpat[0] = 2'b01; vpat[1] = 2'b01;
        send(2'b00, 16'd2, 2'b00, 16'h0001);
        run_cmd(100, at);
        check("tmo done_at", at, 2 + 2 + DT);
        check("tmo err_timeout", err_timeout, 1'b1);
        check("tmo err_overflow", err_overflow, 1'b0);
        @(negedge clk);

        // Overflow: lane 0 reports three times for two rows
        clr_pat();
        vpat[0] = 2'b11; vpat[1] = 2'b11; vpat[2] = 2'b01;
        send(2'b11, 16'd2, 2'b01, 16'h0042);
        check("ovf err_timeout cleared", err_timeout, 1'b0);
        run_cmd(20, at);
        check("ovf done_at", at, 5);
        check("ovf err_overflow", err_overflow, 1'b1);
        @(negedge clk);
        check("ovf sticky in idle", err_overflow, 1'b1);
        clr_pat();
        vpat[0] = 2'b11;
        send(2'b00, 16'd1, 2'b00, 16'h0000);
        check("ovf cleared at accept", err_overflow, 1'b0);
        run_cmd(20, at);
        check("ovf next done_at", at, 4);
        @(negedge clk);

        // Abort in RUN after one issue
        clr_pat();
        send(2'b01, 16'd5, 2'b10, 16'h5555);
        @(negedge clk);
        @(negedge clk);
        row_ready = 1'b0;
        abort     = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        row_ready = 1'b1;
        check("abort busy", busy, 1'b0);
        check("abort pathway", vpu_data_pathway, 4'b0000);
        check("abort cmd_ready", cmd_ready, 1'b1);
        check("abort issues", hs, 1);
        check("abort no done", done_seen, 0);
        @(negedge clk);

        // Reset in the middle of a command
        send(2'b10, 16'd4, 2'b11, 16'h7777);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst cmd_ready", cmd_ready, 1'b0);
        check("midrst busy", busy, 1'b0);
        check("midrst row_valid", row_valid, 1'b0);
        check("midrst pathway", vpu_data_pathway, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst release ready", cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        check("midrst no done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
